// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous wave in clk cycles,
// with a loss-of-clock timeout.
module clock_period_meter #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             ovf,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   cnt_max;
  logic [CNT_W-1:0]       hi_latch;
  logic                   sat;
  logic                   to_hit;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign cnt_max = (cnt == {CNT_W{1'b1}});
  assign cnt_inc = cnt_max ? cnt : cnt + 1'b1;
  // A rise in the same cycle as the timeout condition takes precedence.
  assign to_hit  = (TIMEOUT != 0) && (cnt == TO_VAL) && !rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      s_d    <= s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_latch  <= '0;
      sat       <= 1'b0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        busy    <= 1'b0;
        cnt     <= '0;
        sat     <= 1'b0;
        timeout <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
            busy  <= 1'b1;
          end
          ARM: begin
            if (rise) begin
              cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
              sat   <= 1'b0;
              state <= MEAS;
            end else if (to_hit) begin
              timeout <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          MEAS: begin
            if (rise) begin
              period    <= cnt;
              high_time <= hi_latch;
              ovf       <= sat;
              valid     <= 1'b1;
              timeout   <= 1'b0;
              sat       <= 1'b0;
              cnt       <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (to_hit) begin
              timeout <= 1'b1;
              cnt     <= '0;
              sat     <= 1'b0;
              state   <= ARM;
            end else begin
              cnt <= cnt_inc;
              if (cnt_max) sat <= 1'b1;
              if (fall) hi_latch <= cnt;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: a 32-bit instance with TIMEOUT=100
// and an 8-bit instance with the timeout disabled.
module tb_clock_period_meter;

  logic        clk = 1'b0;
  logic        rst_a, clk_in_a, en_a;
  logic        rst_b, clk_in_b, en_b;
  logic [31:0] period_a, high_time_a;
  logic        valid_a, ovf_a, timeout_a, busy_a;
  logic [7:0]  period_b, high_time_b;
  logic        valid_b, ovf_b, timeout_b, busy_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_p_a, exp_h_a, exp_p_b, exp_h_b;
  logic        exp_o_a, exp_o_b;
  logic        quiet_a = 1'b0;
  logic        prev_a = 1'b0, prev_b = 1'b0;
  int          vcnt_a = 0, vcnt_b = 0;
  int          c0;

  typedef struct {
    bit          sel_b;
    int          hi;
    int          lo;
    int          n;
    logic [31:0] exp_p;
    logic [31:0] exp_h;
    logic        exp_o;
  } vec_t;
  vec_t vecs[6];

  clock_period_meter #(.CNT_W(32), .TIMEOUT(100), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst_a), .clk_in(clk_in_a), .en(en_a),
    .period(period_a), .high_time(high_time_a), .valid(valid_a),
    .ovf(ovf_a), .timeout(timeout_a), .busy(busy_a)
  );

  clock_period_meter #(.CNT_W(8), .TIMEOUT(0), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst_b), .clk_in(clk_in_b), .en(en_b),
    .period(period_b), .high_time(high_time_b), .valid(valid_b),
    .ovf(ovf_b), .timeout(timeout_b), .busy(busy_b)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every valid pulse is compared with the expected measurement
  always @(negedge clk) begin
    if (valid_a) begin
      vcnt_a++;
      chk("a_valid_gap", 96'(prev_a), 96'(0));
      chk("a_valid_while_disabled", 96'(quiet_a), 96'(0));
      chk("a_result", {period_a, high_time_a, ovf_a}, {exp_p_a, exp_h_a, exp_o_a});
    end
    if (valid_b) begin
      vcnt_b++;
      chk("b_valid_gap", 96'(prev_b), 96'(0));
      chk("b_result", {period_b, high_time_b, ovf_b}, {exp_p_b[7:0], exp_h_b[7:0], exp_o_b});
    end
    prev_a = valid_a;
    prev_b = valid_b;
  end

  // driver tasks; all start and end on a negedge
  task automatic set_in(input bit sel_b, input logic v);
    if (sel_b) clk_in_b = v; else clk_in_a = v;
  endtask

  task automatic set_en(input bit sel_b, input logic v);
    if (sel_b) en_b = v; else en_a = v;
  endtask

  task automatic run_wave(input bit sel_b, input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      set_in(sel_b, 1'b1);
      repeat (hi) @(negedge clk);
      set_in(sel_b, 1'b0);
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic restart_a();
    en_a = 1'b0;
    clk_in_a = 1'b0;
    repeat (4) @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b0,   5,   5, 4, 32'd10,  32'd5,   1'b0};
    vecs[1] = '{1'b0,   3,   9, 4, 32'd12,  32'd3,   1'b0};
    vecs[2] = '{1'b0,   1,   3, 5, 32'd4,   32'd1,   1'b0};
    vecs[3] = '{1'b0,   7,   2, 4, 32'd9,   32'd7,   1'b0};
    vecs[4] = '{1'b1, 150, 150, 3, 32'd255, 32'd150, 1'b1};
    vecs[5] = '{1'b1,   5,   5, 4, 32'd10,  32'd5,   1'b0};

    rst_a = 1'b1; rst_b = 1'b1;
    en_a = 1'b0; en_b = 1'b0;
    clk_in_a = 1'b0; clk_in_b = 1'b0;
    exp_p_a = '0; exp_h_a = '0; exp_o_a = 1'b0;
    exp_p_b = '0; exp_h_b = '0; exp_o_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_reset", {period_a, high_time_a, valid_a, ovf_a, timeout_a, busy_a}, 96'(0));
    chk("b_reset", {period_b, high_time_b, valid_b, ovf_b, timeout_b, busy_b}, 96'(0));
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // table-driven waveforms: n rises give n-1 valid pulses
    for (int i = 0; i < 6; i++) begin
      set_en(vecs[i].sel_b, 1'b0);
      set_in(vecs[i].sel_b, 1'b0);
      repeat (4) @(negedge clk);
      if (vecs[i].sel_b) begin
        exp_p_b = vecs[i].exp_p; exp_h_b = vecs[i].exp_h; exp_o_b = vecs[i].exp_o;
        c0 = vcnt_b;
      end else begin
        exp_p_a = vecs[i].exp_p; exp_h_a = vecs[i].exp_h; exp_o_a = vecs[i].exp_o;
        c0 = vcnt_a;
      end
      set_en(vecs[i].sel_b, 1'b1);
      @(negedge clk);
      run_wave(vecs[i].sel_b, vecs[i].hi, vecs[i].lo, vecs[i].n);
      repeat (6) @(negedge clk);
      chk($sformatf("vec%0d_valid_count", i),
          96'(vecs[i].sel_b ? vcnt_b - c0 : vcnt_a - c0), 96'(vecs[i].n - 1));
    end

    // timeout: counter reaches 100 with no rise, 3 cycles of sync latency ahead
    exp_p_a = 32'd10; exp_h_a = 32'd5; exp_o_a = 1'b0;
    restart_a();
    run_wave(1'b0, 5, 5, 3);
    clk_in_a = 1'b1;
    for (int k = 1; k <= 103; k++) begin
      @(negedge clk);
      if (k == 5) clk_in_a = 1'b0;
      if (k == 102) chk("timeout_not_early", 96'(timeout_a), 96'(0));
    end
    chk("timeout_set", 96'(timeout_a), 96'(1));
    chk("timeout_busy", 96'(busy_a), 96'(1));
    chk("timeout_hold", {period_a, high_time_a}, {32'd10, 32'd5});
    c0 = vcnt_a;
    run_wave(1'b0, 5, 5, 3);
    repeat (4) @(negedge clk);
    chk("resume_valid_count", 96'(vcnt_a - c0), 96'(2));
    chk("resume_timeout_clear", 96'(timeout_a), 96'(0));

    // reset while in MEAS with timeout set
    repeat (110) @(negedge clk);
    chk("timeout_again", 96'(timeout_a), 96'(1));
    run_wave(1'b0, 5, 5, 1);
    chk("meas_timeout_busy", {timeout_a, busy_a}, 96'b11);
    rst_a = 1'b1;
    @(negedge clk);
    chk("mid_meas_reset", {period_a, high_time_a, valid_a, ovf_a, timeout_a, busy_a}, 96'(0));
    rst_a = 1'b0;

    // reset on the same edge that would have produced a valid
    run_wave(1'b0, 5, 5, 2);
    c0 = vcnt_a;
    clk_in_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    chk("rst_on_rise_valid", 96'(valid_a), 96'(0));
    rst_a = 1'b0;
    repeat (2) @(negedge clk);
    clk_in_a = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_on_rise_count", 96'(vcnt_a - c0), 96'(0));

    // en dropped mid-period, then re-enabled
    restart_a();
    run_wave(1'b0, 5, 5, 3);
    clk_in_a = 1'b1;
    repeat (5) @(negedge clk);
    en_a = 1'b0;
    quiet_a = 1'b1;
    clk_in_a = 1'b0;
    @(negedge clk);
    chk("en_drop_busy", {busy_a, valid_a}, 96'(0));
    chk("en_drop_hold", {period_a, high_time_a, ovf_a}, {32'd10, 32'd5, 1'b0});
    repeat (4) @(negedge clk);
    run_wave(1'b0, 5, 5, 2);
    quiet_a = 1'b0;
    en_a = 1'b1;
    c0 = vcnt_a;
    run_wave(1'b0, 5, 5, 1);
    chk("reenable_first_rise", 96'(vcnt_a - c0), 96'(0));
    run_wave(1'b0, 5, 5, 2);
    repeat (4) @(negedge clk);
    chk("reenable_valid_count", 96'(vcnt_a - c0), 96'(2));
    chk("reenable_result", {period_a, high_time_a}, {32'd10, 32'd5});

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
